// File: rtl/inv_odd_even_fsm_if.sv
// Bus bundle between the inverse 5/3 lifting sequencer, its column RAM and
// the decode-side control. The sat_o flag exists only when INV_LIFT_SAT_EN
// is defined.
interface inv_odd_even_fsm_if #(
    parameter int unsigned W      = 9,
    parameter int unsigned ADDR_W = 8
);

    // Control side
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [6:0]               state;
    logic                     pass_o;

    // RAM side
    logic [ADDR_W-1:0]        addr;
    logic                     we_1;
    logic signed [W-1:0]      dout;
    logic signed [W-1:0]      res_o;

`ifdef INV_LIFT_SAT_EN
    logic                     sat_o;

    modport master (
        input  start,
        input  dout,
        output busy,
        output done,
        output state,
        output pass_o,
        output addr,
        output we_1,
        output res_o,
        output sat_o
    );

    modport slave (
        output start,
        output dout,
        input  busy,
        input  done,
        input  state,
        input  pass_o,
        input  addr,
        input  we_1,
        input  res_o,
        input  sat_o
    );
`else
    modport master (
        input  start,
        input  dout,
        output busy,
        output done,
        output state,
        output pass_o,
        output addr,
        output we_1,
        output res_o
    );

    modport slave (
        output start,
        output dout,
        input  busy,
        input  done,
        input  state,
        input  pass_o,
        input  addr,
        input  we_1,
        input  res_o
    );
`endif

endinterface

// File: rtl/inv_odd_even_fsm.sv
// Inverse 5/3 lifting sequencer. Rebuilds one column in place in a
// single-port RAM with one cycle of read latency: pass 0 undoes the update
// step on even indices, pass 1 undoes the predict step on odd indices.
// Each sample takes five cycles: read left, read self, read right, compute,
// write back. Optional macro INV_LIFT_SAT_EN: saturate results instead of
// wrapping and expose a sticky sat_o flag.
module inv_odd_even_fsm #(
    parameter int unsigned W      = 9,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N      = 256
) (
    input  logic               clk,
    input  logic               rst_fsm,
    inv_odd_even_fsm_if.master bus
);

    typedef enum logic [6:0] {
        StIdle = 7'b0000001,
        StRdL  = 7'b0000010,
        StRdS  = 7'b0000100,
        StRdR  = 7'b0001000,
        StCalc = 7'b0010000,
        StWr   = 7'b0100000,
        StDone = 7'b1000000
    } state_e;

    localparam logic [ADDR_W-1:0] LastOdd  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LastEven = ADDR_W'(N - 2);
    localparam logic [ADDR_W-1:0] IdxStep  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] IdxOne   = ADDR_W'(1);

    localparam logic signed [W+1:0] RoundTwo = (W + 2)'(2);
    localparam logic signed [W+1:0] SatMax   = (W + 2)'((2 ** (W - 1)) - 1);
    // Bitwise complement of 2**(W-1)-1 is -2**(W-1) at this width
    localparam logic signed [W+1:0] SatMin   = ~SatMax;

    // Left neighbour with mirror at the top edge of the column
    function automatic logic [ADDR_W-1:0] left_of(input logic [ADDR_W-1:0] i);
        return (i == '0) ? IdxOne : i - IdxOne;
    endfunction

    // Right neighbour with mirror at the bottom edge of the column
    function automatic logic [ADDR_W-1:0] right_of(input logic [ADDR_W-1:0] i);
        return (i == LastOdd) ? LastEven : i + IdxOne;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pass_q, pass_d;
    logic signed [W-1:0] l_q, l_d;
    logic signed [W-1:0] s_q, s_d;
    logic signed [W-1:0] res_q, res_d;

    logic signed [W+1:0] l_x, r_x, s_x;
    logic signed [W+1:0] sum_lr;
    logic signed [W+1:0] full;
    logic signed [W-1:0] res_calc;

`ifdef INV_LIFT_SAT_EN
    logic                sat_q, sat_d;
    logic                clamp;
`else
    // Wrap mode keeps only the low W bits of the wide result
    logic                unused_full;
    assign unused_full = ^full[W+1:W];
`endif

    // Lifting arithmetic at W+2 bits; R is taken straight from the RAM in CALC
    always_comb begin
        l_x    = {{2{l_q[W-1]}}, l_q};
        r_x    = {{2{bus.dout[W-1]}}, bus.dout};
        s_x    = {{2{s_q[W-1]}}, s_q};
        sum_lr = '0;
        full   = '0;
        if (!pass_q) begin
            sum_lr = l_x + r_x + RoundTwo;
            full   = s_x - (sum_lr >>> 2);
        end else begin
            sum_lr = l_x + r_x;
            full   = s_x + (sum_lr >>> 1);
        end
`ifdef INV_LIFT_SAT_EN
        clamp    = 1'b0;
        res_calc = full[W-1:0];
        if (full > SatMax) begin
            res_calc = SatMax[W-1:0];
            clamp    = 1'b1;
        end else if (full < SatMin) begin
            res_calc = SatMin[W-1:0];
            clamp    = 1'b1;
        end
`else
        res_calc = full[W-1:0];
`endif
    end

    // Next-state, index/pass bookkeeping and operand capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        l_d     = l_q;
        s_d     = s_q;
        res_d   = res_q;
`ifdef INV_LIFT_SAT_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    state_d = StRdL;
`ifdef INV_LIFT_SAT_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            StRdL: state_d = StRdS;
            StRdS: begin
                l_d     = bus.dout;
                state_d = StRdR;
            end
            StRdR: begin
                s_d     = bus.dout;
                state_d = StCalc;
            end
            StCalc: begin
                res_d   = res_calc;
                state_d = StWr;
`ifdef INV_LIFT_SAT_EN
                if (clamp) begin
                    sat_d = 1'b1;
                end
`endif
            end
            StWr: begin
                if (!pass_q && (idx_q == LastEven)) begin
                    pass_d  = 1'b1;
                    idx_d   = IdxOne;
                    state_d = StRdL;
                end else if (pass_q && (idx_q == LastOdd)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxStep;
                    state_d = StRdL;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered RAM address for the state being entered; held in IDLE and DONE
    always_comb begin
        addr_d = addr_q;
        unique case (state_d)
            StRdL:       addr_d = left_of(idx_d);
            StRdS, StWr: addr_d = idx_d;
            StRdR:       addr_d = right_of(idx_d);
            default:     addr_d = addr_q;
        endcase
    end

    // State and datapath registers; reset wins over start
    always_ff @(posedge clk) begin
        if (rst_fsm) begin
            state_q <= StIdle;
            idx_q   <= '0;
            addr_q  <= '0;
            pass_q  <= 1'b0;
            l_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
`ifdef INV_LIFT_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            l_q     <= l_d;
            s_q     <= s_d;
            res_q   <= res_d;
`ifdef INV_LIFT_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Output decode straight from the one-hot state register
    always_comb begin
        bus.state  = state_q;
        bus.busy   = (state_q == StRdL) || (state_q == StRdS) || (state_q == StRdR) ||
                     (state_q == StCalc) || (state_q == StWr);
        bus.done   = (state_q == StDone);
        bus.we_1   = (state_q == StWr);
        bus.addr   = addr_q;
        bus.res_o  = res_q;
        bus.pass_o = pass_q;
`ifdef INV_LIFT_SAT_EN
        bus.sat_o  = sat_q;
`endif
    end

endmodule
